// File: rtl/mips_shift_pkg.sv
// Shared definitions for the multi-cycle MIPS shift datapath.
// Provides the shifter FSM state encoding, the datapath width constants
// and the shift-mode encoding the control unit drives onto `arith`.
package mips_shift_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic SHIFT_LOGICAL = 1'b0;
    localparam logic SHIFT_ARITH   = 1'b1;

endpackage

// File: rtl/shift_right_step.sv
// Combinational single step of the iterative right shifter.
// Ports:
//   value   - operand for this step
//   k       - shift distance for this step (0..STEP)
//   fill    - bit written into the vacated MSBs
//   shifted - value >> k with the top k bits set to fill
module shift_right_step #(
    parameter int DATA_W = 32,
    parameter int K_W    = 1
) (
    input  logic [DATA_W-1:0] value,
    input  logic [K_W-1:0]    k,
    input  logic              fill,
    output logic [DATA_W-1:0] shifted
);

    logic [DATA_W-1:0] fill_mask;

    // Ones in exactly the k vacated MSB positions.
    assign fill_mask = ~({DATA_W{1'b1}} >> k);
    assign shifted   = (value >> k) | ({DATA_W{fill}} & fill_mask);

endmodule

// File: rtl/iter_shift_right.sv
// Multi-cycle right shifter for srl/sra/srlv/srav.
// Shifts a captured operand right by a captured amount, STEP bits per clock,
// under a start/busy/done handshake from the control FSM.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   start   - request, sampled only while idle
//   flush   - synchronous abort, overrides start
//   arith   - 0 = zero fill, 1 = sign fill
//   shamt   - shift amount, captured at start
//   data_in - operand, captured at start
//   result  - shifted value, stable while idle
//   busy    - high while a shift is in progress
//   done    - one-cycle pulse when result becomes valid
module iter_shift_right #(
    parameter int DATA_W  = mips_shift_pkg::DATA_W,
    parameter int SHAMT_W = mips_shift_pkg::SHAMT_W,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               flush,
    input  logic               arith,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [DATA_W-1:0]  data_in,
    output logic [DATA_W-1:0]  result,
    output logic               busy,
    output logic               done
);

    import mips_shift_pkg::*;

    localparam int K_W = $clog2(STEP + 1);

    state_t             state, state_n;
    logic [DATA_W-1:0]  work, work_n;
    logic [SHAMT_W-1:0] count, count_n;
    logic               fill, fill_n;
    logic               done_q, done_n;
    logic [K_W-1:0]     k;
    logic [DATA_W-1:0]  stepped;

    // Last step may be shorter than STEP when the remaining count is small.
    assign k = (int'(count) >= STEP) ? K_W'(STEP) : K_W'(count);

    shift_right_step #(
        .DATA_W (DATA_W),
        .K_W    (K_W)
    ) u_step (
        .value   (work),
        .k       (k),
        .fill    (fill),
        .shifted (stepped)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_n = state;
        work_n  = work;
        count_n = count;
        fill_n  = fill;
        done_n  = 1'b0;

        if (flush) begin
            // Abort keeps the partial result; only the handshake is cleared.
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n = SHIFT;
                        work_n  = data_in;
                        count_n = shamt;
                        fill_n  = arith & data_in[DATA_W-1];
                    end
                end
                SHIFT: begin
                    work_n  = stepped;
                    count_n = count - SHAMT_W'(k);
                    // Covers both "reached zero now" and "entered with zero".
                    if (count_n == '0) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            work   <= '0;
            count  <= '0;
            fill   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            work   <= work_n;
            count  <= count_n;
            fill   <= fill_n;
            done_q <= done_n;
        end
    end

    assign result = work;
    assign busy   = (state == SHIFT);
    assign done   = done_q;

endmodule

// File: tb/tb_iter_shift_right.sv
// Directed self-checking bench for iter_shift_right.
// Two instances share the operand inputs: one with STEP=1, one with STEP=8.
module tb_iter_shift_right;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start1, start8, flush, arith;
    logic [4:0]  shamt;
    logic [31:0] data_in;
    logic [31:0] result1, result8;
    logic        busy1, busy8, done1, done8;

    int n_cmp = 0;
    int n_bad = 0;

    iter_shift_right #(.DATA_W(32), .SHAMT_W(5), .STEP(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .flush(flush),
        .arith(arith), .shamt(shamt), .data_in(data_in),
        .result(result1), .busy(busy1), .done(done1)
    );

    iter_shift_right #(.DATA_W(32), .SHAMT_W(5), .STEP(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .flush(flush),
        .arith(arith), .shamt(shamt), .data_in(data_in),
        .result(result8), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start on one instance for a single edge (E0).
    task automatic do_start(input bit sel, input logic [31:0] d,
                            input logic [4:0] s, input logic a);
        data_in = d; shamt = s; arith = a;
        if (sel) start8 = 1'b1; else start1 = 1'b1;
        tick();
        start1 = 1'b0; start8 = 1'b0;
        data_in = 32'hDEAD_BEEF; shamt = 5'd17; arith = ~a;
    endtask

    // Counts cycles until done, bounded so a dead DUT cannot hang the run.
    task automatic wait_done(input bit sel, output int cycles);
        cycles = 0;
        while (!(sel ? done8 : done1) && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        n_cmp++; if (result1 !== 32'h0) begin n_bad++; $display("FAIL reset_result got=%h exp=%h", result1, 32'h0); end
        n_cmp++; if ({busy1, done1} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_done got=%b exp=00", {busy1, done1}); end
        reset_n = 1'b1;
        tick();
        do_start(1'b0, 32'h0000_F000, 5'd8, 1'b0);
        repeat (3) tick();
        n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL midshift_busy got=%b exp=1", busy1); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (result1 !== 32'h0) begin n_bad++; $display("FAIL async_reset_result got=%h exp=%h", result1, 32'h0); end
        n_cmp++; if ({busy1, done1} !== 2'b00) begin n_bad++; $display("FAIL async_reset_busy_done got=%b exp=00", {busy1, done1}); end
        #2 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_logical();
        int cyc;
        do_start(1'b0, 32'hF000_0000, 5'd4, 1'b0);
        n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL logical_busy got=%b exp=1", busy1); end
        wait_done(1'b0, cyc);
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL logical_latency got=%0d exp=4", cyc); end
        n_cmp++; if (result1 !== 32'h0F00_0000) begin n_bad++; $display("FAIL logical_result got=%h exp=%h", result1, 32'h0F00_0000); end
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL logical_busy_at_done got=%b exp=0", busy1); end
        tick();
        n_cmp++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL logical_done_pulse got=%b exp=0", done1); end
        n_cmp++; if (result1 !== 32'h0F00_0000) begin n_bad++; $display("FAIL logical_result_hold got=%h exp=%h", result1, 32'h0F00_0000); end
    endtask

    task automatic test_arith();
        int cyc;
        do_start(1'b0, 32'h8000_0000, 5'd31, 1'b1);
        wait_done(1'b0, cyc);
        n_cmp++; if (cyc !== 31) begin n_bad++; $display("FAIL arith_latency got=%0d exp=31", cyc); end
        n_cmp++; if (result1 !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL arith_result got=%h exp=%h", result1, 32'hFFFF_FFFF); end
        tick();
        do_start(1'b1, 32'h8000_0000, 5'd31, 1'b1);
        wait_done(1'b1, cyc);
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL arith8_latency got=%0d exp=4", cyc); end
        n_cmp++; if (result8 !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL arith8_result got=%h exp=%h", result8, 32'hFFFF_FFFF); end
        tick();
        // Positive operand with sign fill requested must still zero fill.
        do_start(1'b1, 32'h7000_0000, 5'd12, 1'b1);
        wait_done(1'b1, cyc);
        n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL arith8_pos_latency got=%0d exp=2", cyc); end
        n_cmp++; if (result8 !== 32'h0007_0000) begin n_bad++; $display("FAIL arith8_pos_result got=%h exp=%h", result8, 32'h0007_0000); end
        tick();
    endtask

    task automatic test_zero_shift();
        int cyc;
        do_start(1'b0, 32'h1234_5678, 5'd0, 1'b0);
        n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL zero_busy got=%b exp=1", busy1); end
        wait_done(1'b0, cyc);
        n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL zero_latency got=%0d exp=1", cyc); end
        n_cmp++; if (result1 !== 32'h1234_5678) begin n_bad++; $display("FAIL zero_result got=%h exp=%h", result1, 32'h1234_5678); end
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL zero_busy_at_done got=%b exp=0", busy1); end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        do_start(1'b0, 32'h0000_0100, 5'd2, 1'b0);
        // Request while busy: must be ignored.
        data_in = 32'hFFFF_FFFF; shamt = 5'd1; arith = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_done(1'b0, cyc);
        n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL b2b_first_latency got=%0d exp=1", cyc); end
        n_cmp++; if (result1 !== 32'h0000_0040) begin n_bad++; $display("FAIL b2b_first_result got=%h exp=%h", result1, 32'h0000_0040); end
        // Request in the done cycle: accepted with no bubble.
        data_in = 32'hFFFF_FFFF; shamt = 5'd1; arith = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n_cmp++; if ({busy1, done1} !== 2'b10) begin n_bad++; $display("FAIL b2b_accept got=%b exp=10", {busy1, done1}); end
        wait_done(1'b0, cyc);
        n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL b2b_second_latency got=%0d exp=1", cyc); end
        n_cmp++; if (result1 !== 32'h7FFF_FFFF) begin n_bad++; $display("FAIL b2b_second_result got=%h exp=%h", result1, 32'h7FFF_FFFF); end
        tick();
    endtask

    task automatic test_flush();
        bit seen_done = 1'b0;
        do_start(1'b0, 32'h0000_00FF, 5'd16, 1'b0);
        repeat (5) tick();
        n_cmp++; if (result1 !== 32'h0000_0007) begin n_bad++; $display("FAIL flush_partial got=%h exp=%h", result1, 32'h0000_0007); end
        flush = 1'b1; start1 = 1'b1; data_in = 32'h0000_0123; shamt = 5'd3;
        tick();
        flush = 1'b0; start1 = 1'b0;
        n_cmp++; if ({busy1, done1} !== 2'b00) begin n_bad++; $display("FAIL flush_idle got=%b exp=00", {busy1, done1}); end
        n_cmp++; if (result1 !== 32'h0000_0007) begin n_bad++; $display("FAIL flush_hold got=%h exp=%h", result1, 32'h0000_0007); end
        repeat (20) begin
            tick();
            if (done1 || busy1) seen_done = 1'b1;
        end
        n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL flush_start_dropped got=%b exp=0", seen_done); end
        n_cmp++; if (result1 !== 32'h0000_0007) begin n_bad++; $display("FAIL flush_hold_late got=%h exp=%h", result1, 32'h0000_0007); end
    endtask

    initial begin
        reset_n = 1'b0; start1 = 1'b0; start8 = 1'b0; flush = 1'b0;
        arith = 1'b0; shamt = '0; data_in = '0;
        test_reset();
        test_logical();
        test_arith();
        test_zero_shift();
        test_back_to_back();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
